// File: rtl/ifft_butterfly_dif_if.sv
// Handshake and sample bus of the inverse DIF radix-2 butterfly.
// The slave modport is the butterfly; master is the side that feeds and drains it.
interface ifft_butterfly_dif_if #(
   parameter int DATA_WIDTH = 16,
   parameter int MUTI       = 1
);
   localparam int W = MUTI * DATA_WIDTH;

   logic                in_valid;
   logic                in_ready;
   logic signed [W-1:0] xp_real;
   logic signed [W-1:0] xp_imag;
   logic signed [W-1:0] xq_real;
   logic signed [W-1:0] xq_imag;
   logic signed [14:0]  factor_real;
   logic signed [14:0]  factor_imag;
   logic                out_valid;
   logic                out_ready;
   logic signed [W-1:0] yp_real;
   logic signed [W-1:0] yp_imag;
   logic signed [W-1:0] yq_real;
   logic signed [W-1:0] yq_imag;

   modport master (
      output in_valid, xp_real, xp_imag, xq_real, xq_imag, factor_real, factor_imag, out_ready,
      input  in_ready, out_valid, yp_real, yp_imag, yq_real, yq_imag
   );

   modport slave (
      input  in_valid, xp_real, xp_imag, xq_real, xq_imag, factor_real, factor_imag, out_ready,
      output in_ready, out_valid, yp_real, yp_imag, yq_real, yq_imag
   );
endinterface

// File: rtl/ifft_butterfly_dif.sv
// Radix-2 DIF inverse butterfly: yp = (xp+xq)/2, yq = (xp-xq)*conj(factor)/2.
// Three-stage pipeline (add/sub, multiply, round/saturate) under one global advance.
module ifft_butterfly_dif #(
   parameter int DATA_WIDTH = 16,
   parameter int MUTI       = 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   ifft_butterfly_dif_if.slave         bus
);
   localparam int W  = MUTI * DATA_WIDTH;
   localparam int PW = W + 17;

   localparam logic signed [W:0]    ONE_HALF_LSB = {{W{1'b0}}, 1'b1};
   localparam logic signed [PW-1:0] Q14_ROUND    = {{(PW-14){1'b0}}, 1'b1, 13'd0};

   // Clamp a W+3 bit value into the signed W-bit range.
   function automatic logic signed [W-1:0] sat_w(input logic signed [W+2:0] v);
      if (v[W+2:W-1] == {4{v[W+2]}}) begin
         return v[W-1:0];
      end else if (v[W+2]) begin
         return {1'b1, {(W-1){1'b0}}};
      end else begin
         return {1'b0, {(W-1){1'b1}}};
      end
   endfunction

   logic                adv_s;

   logic                v1_r;
   logic signed [W:0]   s1r_r, s1i_r, d1r_r, d1i_r;
   logic signed [14:0]  f1r_r, f1i_r;

   logic                v2_r;
   logic signed [W:0]   s2r_r, s2i_r;
   logic signed [PW-1:0] p2r_r, p2i_r;

   logic                v3_r;
   logic signed [W-1:0] ypr_r, ypi_r, yqr_r, yqi_r;

   logic signed [W:0]    sr_s, si_s, dr_s, di_s;
   logic signed [PW-1:0] pr_s, pi_s;
   logic signed [W-1:0]  ypr_s, ypi_s, yqr_s, yqi_s;

   assign adv_s = !v3_r || bus.out_ready;

   // Stage 1 sum/difference of the inputs, one guard bit each.
   always_comb begin
      sr_s = (W+1)'(bus.xp_real) + (W+1)'(bus.xq_real);
      si_s = (W+1)'(bus.xp_imag) + (W+1)'(bus.xq_imag);
      dr_s = (W+1)'(bus.xp_real) - (W+1)'(bus.xq_real);
      di_s = (W+1)'(bus.xp_imag) - (W+1)'(bus.xq_imag);
   end

   // Stage 2 complex multiply of the difference by the conjugated twiddle.
   always_comb begin
      pr_s = PW'(d1r_r) * PW'(f1r_r) + PW'(d1i_r) * PW'(f1i_r);
      pi_s = PW'(d1i_r) * PW'(f1r_r) - PW'(d1r_r) * PW'(f1i_r);
   end

   // Stage 3 round-half-up; the q path drops Q13 plus the /2 in one shift.
   always_comb begin
      ypr_s = W'((s2r_r + ONE_HALF_LSB) >>> 1);
      ypi_s = W'((s2i_r + ONE_HALF_LSB) >>> 1);
      yqr_s = sat_w((W+3)'((p2r_r + Q14_ROUND) >>> 14));
      yqi_s = sat_w((W+3)'((p2i_r + Q14_ROUND) >>> 14));
   end

   // Pipeline registers; every stage shifts together on adv_s, otherwise holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1_r  <= 1'b0;
         s1r_r <= '0;
         s1i_r <= '0;
         d1r_r <= '0;
         d1i_r <= '0;
         f1r_r <= '0;
         f1i_r <= '0;
         v2_r  <= 1'b0;
         s2r_r <= '0;
         s2i_r <= '0;
         p2r_r <= '0;
         p2i_r <= '0;
         v3_r  <= 1'b0;
         ypr_r <= '0;
         ypi_r <= '0;
         yqr_r <= '0;
         yqi_r <= '0;
      end else if (adv_s) begin
         v1_r  <= bus.in_valid;
         s1r_r <= sr_s;
         s1i_r <= si_s;
         d1r_r <= dr_s;
         d1i_r <= di_s;
         f1r_r <= bus.factor_real;
         f1i_r <= bus.factor_imag;
         v2_r  <= v1_r;
         s2r_r <= s1r_r;
         s2i_r <= s1i_r;
         p2r_r <= pr_s;
         p2i_r <= pi_s;
         v3_r  <= v2_r;
         ypr_r <= ypr_s;
         ypi_r <= ypi_s;
         yqr_r <= yqr_s;
         yqi_r <= yqi_s;
      end
   end

   assign bus.in_ready  = adv_s;
   assign bus.out_valid = v3_r;
   assign bus.yp_real   = ypr_r;
   assign bus.yp_imag   = ypi_r;
   assign bus.yq_real   = yqr_r;
   assign bus.yq_imag   = yqi_r;
endmodule

// File: tb/tb_ifft_butterfly_dif.sv
// Directed bench for ifft_butterfly_dif: arithmetic corners, latency, backpressure, reset.
module tb_ifft_butterfly_dif;
   localparam int W = 16;
   typedef logic signed [W-1:0] smp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   ifft_butterfly_dif_if #(.DATA_WIDTH(16), .MUTI(1)) bus ();
   ifft_butterfly_dif #(.DATA_WIDTH(16), .MUTI(1)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input smp_t pr, input smp_t pi, input smp_t qr, input smp_t qi,
                        input logic signed [14:0] fr, input logic signed [14:0] fi);
      bus.xp_real     = pr;
      bus.xp_imag     = pi;
      bus.xq_real     = qr;
      bus.xq_imag     = qi;
      bus.factor_real = fr;
      bus.factor_imag = fi;
   endtask

   // One beat into an idle pipe; returns the result and edges until out_valid.
   task automatic run_beat(input smp_t pr, input smp_t pi, input smp_t qr, input smp_t qi,
                           input logic signed [14:0] fr, input logic signed [14:0] fi,
                           output smp_t ypr, output smp_t ypi, output smp_t yqr, output smp_t yqi,
                           output int lat);
      drive(pr, pi, qr, qi, fr, fi);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 10) begin
         tick();
         lat++;
      end
      ypr = bus.yp_real;
      ypi = bus.yp_imag;
      yqr = bus.yq_real;
      yqi = bus.yq_imag;
      tick();
   endtask

   task automatic test_reset();
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      drive(16'sd0, 16'sd0, 16'sd0, 16'sd0, 15'sd0, 15'sd0);
      #2;
      n_tests++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
      n_tests++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
      n_tests++;
      if ({bus.yp_real, bus.yp_imag, bus.yq_real, bus.yq_imag} !== 64'd0) begin
         n_fail++; $display("FAIL reset_outputs: got %h expected 0", {bus.yp_real, bus.yp_imag, bus.yq_real, bus.yq_imag});
      end
      #10 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_real_twiddle();
      smp_t a, b, c, d; int lat;
      run_beat(16'sd1000, 16'sd0, 16'sd200, 16'sd0, 15'sd8192, 15'sd0, a, b, c, d, lat);
      n_tests++;
      if (lat !== 3) begin n_fail++; $display("FAIL real_latency: got %0d expected 3", lat); end
      n_tests++;
      if (a !== 16'sd600 || b !== 16'sd0) begin n_fail++; $display("FAIL real_yp: got (%0d,%0d) expected (600,0)", a, b); end
      n_tests++;
      if (c !== 16'sd400 || d !== 16'sd0) begin n_fail++; $display("FAIL real_yq: got (%0d,%0d) expected (400,0)", c, d); end
   endtask

   task automatic test_conjugate();
      smp_t a, b, c, d; int lat;
      run_beat(16'sd1000, 16'sd0, 16'sd200, 16'sd0, 15'sd0, -15'sd8192, a, b, c, d, lat);
      n_tests++;
      if (a !== 16'sd600 || b !== 16'sd0) begin n_fail++; $display("FAIL conj_yp: got (%0d,%0d) expected (600,0)", a, b); end
      n_tests++;
      if (c !== 16'sd0 || d !== 16'sd400) begin n_fail++; $display("FAIL conj_yq: got (%0d,%0d) expected (0,400)", c, d); end
   endtask

   task automatic test_saturation();
      smp_t a, b, c, d; int lat;
      run_beat(16'sd32767, 16'sd0, -16'sd32768, 16'sd0, 15'sd8192, 15'sd0, a, b, c, d, lat);
      n_tests++;
      if (a !== 16'sd0 || b !== 16'sd0) begin n_fail++; $display("FAIL sat_yp: got (%0d,%0d) expected (0,0)", a, b); end
      n_tests++;
      if (c !== 16'sd32767 || d !== 16'sd0) begin n_fail++; $display("FAIL sat_yq: got (%0d,%0d) expected (32767,0)", c, d); end
   endtask

   task automatic test_neg_round();
      smp_t a, b, c, d; int lat;
      run_beat(-16'sd3, 16'sd0, 16'sd0, 16'sd0, 15'sd8192, 15'sd0, a, b, c, d, lat);
      n_tests++;
      if (a !== -16'sd1 || b !== 16'sd0) begin n_fail++; $display("FAIL negrnd_yp: got (%0d,%0d) expected (-1,0)", a, b); end
      n_tests++;
      if (c !== -16'sd1 || d !== 16'sd0) begin n_fail++; $display("FAIL negrnd_yq: got (%0d,%0d) expected (-1,0)", c, d); end
   endtask

   // Beat i = xp (10i,-10i), xq 0, factor 1.0 -> every output lane is (5i,-5i).
   task automatic test_back_to_back();
      bus.out_ready = 1'b1;
      for (int c = 0; c < 8; c++) begin
         if (c < 4) begin
            drive(16'(10*(c+1)), 16'(-10*(c+1)), 16'sd0, 16'sd0, 15'sd8192, 15'sd0);
            bus.in_valid = 1'b1;
         end else begin
            bus.in_valid = 1'b0;
         end
         #1;
         n_tests++;
         if (c >= 3 && c < 7) begin
            if (bus.out_valid !== 1'b1 || bus.yp_real !== 16'(5*(c-2)) || bus.yq_imag !== 16'(-5*(c-2))) begin
               n_fail++;
               $display("FAIL b2b_cycle%0d: got v=%b yp=%0d yq_i=%0d expected v=1 yp=%0d yq_i=%0d",
                        c, bus.out_valid, bus.yp_real, bus.yq_imag, 5*(c-2), -5*(c-2));
            end
         end else if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_bubble%0d: got out_valid %b expected 0", c, bus.out_valid);
         end
         tick();
      end
   endtask

   task automatic test_backpressure();
      int sent = 0;
      int got  = 0;
      int cyc  = 0;
      logic stall;
      logic [4*W:0] held = '0;
      while (got < 10 && cyc < 80) begin
         stall = (cyc >= 6 && cyc < 11);
         bus.out_ready = !stall;
         if (sent < 10) begin
            drive(16'(10*(sent+1)), 16'(-10*(sent+1)), 16'sd0, 16'sd0, 15'sd8192, 15'sd0);
            bus.in_valid = 1'b1;
         end else begin
            bus.in_valid = 1'b0;
         end
         #1;
         if (stall) begin
            n_tests++;
            if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready_cyc%0d: got %b expected 0", cyc, bus.in_ready); end
            if (cyc > 6) begin
               n_tests++;
               if ({bus.out_valid, bus.yp_real, bus.yp_imag, bus.yq_real, bus.yq_imag} !== held) begin
                  n_fail++;
                  $display("FAIL bp_hold_cyc%0d: got %h expected %h", cyc,
                           {bus.out_valid, bus.yp_real, bus.yp_imag, bus.yq_real, bus.yq_imag}, held);
               end
            end
            held = {bus.out_valid, bus.yp_real, bus.yp_imag, bus.yq_real, bus.yq_imag};
         end
         if (bus.in_valid && bus.in_ready) sent++;
         if (bus.out_valid && bus.out_ready) begin
            got++;
            n_tests++;
            if (bus.yp_real !== 16'(5*got) || bus.yp_imag !== 16'(-5*got) ||
                bus.yq_real !== 16'(5*got) || bus.yq_imag !== 16'(-5*got)) begin
               n_fail++;
               $display("FAIL bp_order_beat%0d: got (%0d,%0d,%0d,%0d) expected (%0d,%0d,%0d,%0d)", got,
                        bus.yp_real, bus.yp_imag, bus.yq_real, bus.yq_imag, 5*got, -5*got, 5*got, -5*got);
            end
         end
         tick();
         cyc++;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      n_tests++;
      if (got != 10) begin n_fail++; $display("FAIL bp_count: got %0d beats expected 10", got); end
      for (int k = 0; k < 5; k++) begin
         n_tests++;
         if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_extra_beat%0d: got out_valid %b expected 0", k, bus.out_valid); end
         tick();
      end
   endtask

   task automatic test_reset_midstream();
      smp_t a, b, c, d; int lat;
      int stale = 0;
      bus.out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         drive(16'(100*(k+1)), 16'sd50, 16'sd20, 16'sd0, 15'sd8192, 15'sd0);
         bus.in_valid = 1'b1;
         tick();
      end
      bus.in_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %b expected 0", bus.out_valid); end
      n_tests++;
      if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b expected 1", bus.in_ready); end
      n_tests++;
      if (bus.yp_real !== 16'sd0 || bus.yq_real !== 16'sd0) begin
         n_fail++; $display("FAIL rstmid_data: got yp=%0d yq=%0d expected 0", bus.yp_real, bus.yq_real);
      end
      tick();
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         if (bus.out_valid !== 1'b0) stale++;
         tick();
      end
      n_tests++;
      if (stale != 0) begin n_fail++; $display("FAIL rstmid_stale: got %0d valid cycles expected 0", stale); end
      run_beat(16'sd1000, 16'sd0, 16'sd200, 16'sd0, 15'sd8192, 15'sd0, a, b, c, d, lat);
      n_tests++;
      if (lat !== 3 || a !== 16'sd600 || c !== 16'sd400) begin
         n_fail++; $display("FAIL rstmid_first_beat: got lat=%0d yp=%0d yq=%0d expected lat=3 yp=600 yq=400", lat, a, c);
      end
   endtask

   initial begin
      test_reset();
      test_real_twiddle();
      test_conjugate();
      test_saturation();
      test_neg_round();
      test_back_to_back();
      test_backpressure();
      test_reset_midstream();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
